// File: rtl/tcp_tx_sequencer.sv
// Transmit-side sequencer driving one TCP encoder per segment.
// Optional WAIT_FIN abort timer enabled by defining TCP_TX_SEQ_TIMEOUT_EN.
module tcp_tx_sequencer #(
  parameter int unsigned MAX_LEN = 1460,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isn_load,
  input  logic [31:0] isn,
  input  logic        req,
  input  logic [15:0] req_len,
  input  logic [5:0]  req_flags,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [31:0] pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic        enc_start,
  output logic        enc_data_av,
  output logic [31:0] enc_data,
  output logic [15:0] enc_len_in,
  output logic [31:0] enc_seq_num,
  output logic [5:0]  enc_flags,
  input  logic        enc_fin,
  output logic [31:0] snd_nxt
);

  typedef enum logic [2:0] {StIdle, StStart, StStream, StWaitFin, StDone} state_e;

  state_e      state_q;
  logic [15:0] words_q;
  logic [31:0] keep;

`ifdef TCP_TX_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] cnt_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      words_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      enc_start   <= 1'b0;
      enc_len_in  <= '0;
      enc_seq_num <= '0;
      enc_flags   <= '0;
      snd_nxt     <= '0;
`ifdef TCP_TX_SEQ_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      enc_start <= 1'b0;
`ifdef TCP_TX_SEQ_TIMEOUT_EN
      if (state_q != StWaitFin) cnt_q <= '0;
`endif
      unique case (state_q)
        StIdle: begin
          if (isn_load) begin
            snd_nxt <= isn;
          end else if (req) begin
            if (req_len > 16'(MAX_LEN)) begin
              err <= 1'b1;
            end else begin
              enc_len_in  <= req_len;
              enc_flags   <= req_flags;
              enc_seq_num <= snd_nxt;
              words_q     <= {2'b00, req_len[15:2]} + {15'd0, |req_len[1:0]};
              enc_start   <= 1'b1;
              busy        <= 1'b1;
              state_q     <= StStart;
            end
          end
        end
        StStart: begin
          if (words_q == '0) begin
            state_q <= StWaitFin;
          end else if (pl_valid) begin
            words_q <= words_q - 16'd1;
            state_q <= (words_q == 16'd1) ? StWaitFin : StStream;
          end else begin
            state_q <= StStream;
          end
        end
        StStream: begin
          if (pl_valid) begin
            words_q <= words_q - 16'd1;
            if (words_q == 16'd1) state_q <= StWaitFin;
          end
        end
        StWaitFin: begin
          if (enc_fin) begin
            done    <= 1'b1;
            state_q <= StDone;
          end
`ifdef TCP_TX_SEQ_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            // Abort leaves snd_nxt untouched so the segment can be resent.
            err     <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StDone: begin
          snd_nxt <= enc_seq_num + {16'd0, enc_len_in} + {31'd0, enc_flags[1]} +
                     {31'd0, enc_flags[0]};
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pl_ready    = ((state_q == StStart) || (state_q == StStream)) && (words_q != '0);
  assign enc_data_av = pl_ready & pl_valid;

  // Zero the bytes of the final word that lie past the segment length.
  always_comb begin
    keep = 32'hFFFF_FFFF;
    if (words_q == 16'd1) begin
      case (enc_len_in[1:0])
        2'd1:    keep = 32'hFF00_0000;
        2'd2:    keep = 32'hFFFF_0000;
        2'd3:    keep = 32'hFFFF_FF00;
        default: keep = 32'hFFFF_FFFF;
      endcase
    end
  end

  assign enc_data = pl_ready ? (pl_data & keep) : '0;

endmodule

// File: tb/tb_tcp_tx_sequencer.sv
// Randomized self-checking bench for tcp_tx_sequencer against a segment-level model.
module tb_tcp_tx_sequencer;
  localparam int unsigned MaxLen  = 1460;
  localparam int unsigned Timeout = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        isn_load = 1'b0;
  logic [31:0] isn = '0;
  logic        req = 1'b0;
  logic [15:0] req_len = '0;
  logic [5:0]  req_flags = '0;
  logic        busy, done, err;
  logic [31:0] pl_data = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic        enc_start, enc_data_av;
  logic [31:0] enc_data;
  logic [15:0] enc_len_in;
  logic [31:0] enc_seq_num;
  logic [5:0]  enc_flags;
  logic        enc_fin = 1'b0;
  logic [31:0] snd_nxt;

  always #5 clk = ~clk;

  tcp_tx_sequencer #(.MAX_LEN(MaxLen), .TIMEOUT(Timeout)) dut (
    .clk(clk), .reset(reset), .isn_load(isn_load), .isn(isn), .req(req),
    .req_len(req_len), .req_flags(req_flags), .busy(busy), .done(done), .err(err),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .enc_start(enc_start),
    .enc_data_av(enc_data_av), .enc_data(enc_data), .enc_len_in(enc_len_in),
    .enc_seq_num(enc_seq_num), .enc_flags(enc_flags), .enc_fin(enc_fin), .snd_nxt(snd_nxt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Segment-level model state
  int          ph = 0;  // 0 idle, 1 segment in flight, 2 completion cycle
  int unsigned m_c, m_words, m_fwd, m_wc;
  logic [15:0] m_len;
  logic [5:0]  m_flags;
  logic [31:0] m_seq;
  logic [31:0] m_snd = '0;
  bit          m_err = 1'b0;

  // Observation counters, cleared per directed test
  int          n_start, n_av, n_done, n_err, n_busy, n_rdy;
  bit          start_av;
  logic [31:0] last_data;

  // Stimulus knobs for the payload/fin driver
  int unsigned valid_pct = 100;
  int unsigned fin_pct = 0;
  bit          vq[$];

  function automatic logic [31:0] expect_data(input logic [31:0] d, input int unsigned idx,
                                              input int unsigned words, input logic [15:0] len);
    int r;
    r = int'(len % 16'd4);
    if (idx == words - 1 && r != 0) return d & ~(32'hFFFF_FFFF >> (8 * r));
    return d;
  endfunction

  always @(posedge clk) begin
    #1;
    if (vq.size() > 0) pl_valid = vq.pop_front();
    else pl_valid = ($urandom_range(99) < valid_pct);
    pl_data = $urandom;
    enc_fin = ($urandom_range(99) < fin_pct);
  end

  always @(negedge clk) begin : cmp
    bit exp_rdy;
    bit waiting;
    if (!reset) begin
      ph = 0; m_snd = '0; m_err = 1'b0;
    end else begin
      exp_rdy = (ph == 1) && (m_fwd < m_words);
      chk("busy", {31'd0, busy}, {31'd0, ph != 0});
      chk("done", {31'd0, done}, {31'd0, ph == 2});
      chk("err", {31'd0, err}, {31'd0, m_err});
      chk("enc_start", {31'd0, enc_start}, {31'd0, ph == 1 && m_c == 1});
      chk("pl_ready", {31'd0, pl_ready}, {31'd0, exp_rdy});
      chk("enc_data_av", {31'd0, enc_data_av}, {31'd0, exp_rdy && pl_valid});
      chk("snd_nxt", snd_nxt, m_snd);
      if (ph != 0) begin
        chk("enc_seq_num", enc_seq_num, m_seq);
        chk("enc_flags", {26'd0, enc_flags}, {26'd0, m_flags});
        chk("enc_len_in", {16'd0, enc_len_in}, {16'd0, m_len});
      end
      if (exp_rdy && pl_valid) chk("enc_data", enc_data, expect_data(pl_data, m_fwd, m_words, m_len));
      if (enc_start) n_start++;
      if (enc_start && enc_data_av) start_av = 1'b1;
      if (enc_data_av) begin n_av++; last_data = enc_data; end
      if (done) n_done++;
      if (err) n_err++;
      if (busy) n_busy++;
      if (pl_ready) n_rdy++;
      m_err = 1'b0;
      case (ph)
        0: begin
          if (isn_load) m_snd = isn;
          else if (req) begin
            if (int'(req_len) > int'(MaxLen)) m_err = 1'b1;
            else begin
              m_len = req_len; m_flags = req_flags; m_seq = m_snd;
              m_words = (int'(req_len) + 3) / 4;
              m_fwd = 0; m_c = 1; m_wc = 0; ph = 1;
            end
          end
        end
        1: begin
          waiting = (m_c >= 2) && (m_fwd == m_words);
          if (exp_rdy && pl_valid) m_fwd++;
          if (waiting) begin
            if (enc_fin) ph = 2;
`ifdef TCP_TX_SEQ_TIMEOUT_EN
            else if (m_wc == Timeout - 1) begin m_err = 1'b1; ph = 0; end
            else m_wc++;
`endif
          end
          m_c++;
        end
        default: begin
          m_snd = m_seq + {16'd0, m_len} + {31'd0, m_flags[1]} + {31'd0, m_flags[0]};
          ph = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    n_start = 0; n_av = 0; n_done = 0; n_err = 0; n_busy = 0; n_rdy = 0;
    start_av = 1'b0; last_data = '0;
  endtask

  task automatic load_isn(input logic [31:0] v);
    isn_load = 1'b1; isn = v;
    tick();
    isn_load = 1'b0;
  endtask

  task automatic send_req(input logic [15:0] len, input logic [5:0] flags);
    req = 1'b1; req_len = len; req_flags = flags;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 4000; i++) begin
      if (ph == 0 && !busy) return;
      tick();
    end
    checks++; errors++;
    $display("FAIL %s: segment did not finish, busy=%b, expected idle", name, busy);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_busy"}, {31'd0, busy}, 0);
    chk({name, "_done"}, {31'd0, done}, 0);
    chk({name, "_err"}, {31'd0, err}, 0);
    chk({name, "_pl_ready"}, {31'd0, pl_ready}, 0);
    chk({name, "_enc_start"}, {31'd0, enc_start}, 0);
    chk({name, "_enc_data_av"}, {31'd0, enc_data_av}, 0);
    chk({name, "_enc_data"}, enc_data, 0);
    chk({name, "_enc_len_in"}, {16'd0, enc_len_in}, 0);
    chk({name, "_enc_seq_num"}, enc_seq_num, 0);
    chk({name, "_enc_flags"}, {26'd0, enc_flags}, 0);
    chk({name, "_snd_nxt"}, snd_nxt, 0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] len;
    clear_mon();
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Three-word segment, last word 3 bytes, fin a few cycles after the data
    load_isn(32'h0000_0100);
    clear_mon(); fin_pct = 0; valid_pct = 100;
    send_req(16'd11, 6'b000000);
    for (int i = 0; i < 50 && n_av < 3; i++) tick();
    repeat (5) tick();
    fin_pct = 100;
    wait_idle("len11");
    fin_pct = 0;
    chk("len11_starts", n_start, 1);
    chk("len11_start_with_av", {31'd0, start_av}, 1);
    chk("len11_words", n_av, 3);
    chk("len11_last_low_byte", {24'd0, last_data[7:0]}, 0);
    chk("len11_done", n_done, 1);
    chk("len11_snd_nxt", snd_nxt, 32'h0000_010B);

    // Two words with a two-cycle gap between them
    clear_mon(); fin_pct = 100;
    vq = '{1'b1, 1'b0, 1'b0, 1'b1};
    send_req(16'd8, 6'b000000);
    wait_idle("gap");
    chk("gap_words", n_av, 2);
    chk("gap_ready_cycles", n_rdy, 4);
    chk("gap_snd_nxt", snd_nxt, 32'h0000_0113);

    // Zero-length SYN wrapping the sequence space
    load_isn(32'hFFFF_FFFF);
    clear_mon();
    send_req(16'd0, 6'b000010);
    wait_idle("syn");
    chk("syn_starts", n_start, 1);
    chk("syn_start_with_av", {31'd0, start_av}, 0);
    chk("syn_words", n_av, 0);
    chk("syn_snd_nxt", snd_nxt, 32'h0000_0000);

    // Oversized request is rejected
    clear_mon();
    send_req(16'd1461, 6'h3F);
    tick(); tick();
    chk("big_err", n_err, 1);
    chk("big_busy", n_busy, 0);
    chk("big_starts", n_start, 0);
    chk("big_snd_nxt", snd_nxt, 32'h0000_0000);

    // Asynchronous reset in the middle of the data phase
    load_isn(32'h0000_1234);
    clear_mon(); fin_pct = 0; valid_pct = 50;
    send_req(16'd16, 6'b000000);
    tick(); tick();
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    tick(); tick();
    reset = 1'b1;
    tick();
    clear_mon(); fin_pct = 100; valid_pct = 100;
    send_req(16'd4, 6'b000000);
    wait_idle("after_reset");
    chk("after_reset_done", n_done, 1);
    chk("after_reset_words", n_av, 1);
    chk("after_reset_snd_nxt", snd_nxt, 32'h0000_0004);

`ifdef TCP_TX_SEQ_TIMEOUT_EN
    // Missing fin aborts the segment
    clear_mon(); fin_pct = 0;
    send_req(16'd4, 6'b000000);
    wait_idle("timeout");
    tick();
    chk("timeout_err", n_err, 1);
    chk("timeout_done", n_done, 0);
    chk("timeout_busy_cycles", n_busy, 17);
    chk("timeout_snd_nxt", snd_nxt, 32'h0000_0004);
`endif

    // Randomized segments
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(7) == 0) load_isn($urandom);
      case ($urandom_range(9))
        0: len = 16'd0;
        1: len = 16'(MaxLen);
        2: len = 16'(MaxLen + 1 + $urandom_range(500));
        default: len = 16'($urandom_range(40, 1));
      endcase
      valid_pct = (len > 16'd100) ? 100 : $urandom_range(100, 30);
      fin_pct = $urandom_range(60, 10);
      send_req(len, 6'($urandom));
      wait_idle("random");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
